// File: rtl/dsp19x2_mode_bits_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : dsp19x2_mode_bits_unpacker
//  Purpose  : Receives the DSP19X2 MODE_BITS configuration word as a serial,
//             MSB-first stream with a valid/ready handshake. It validates the
//             terminal flag bit and unpacks the word into eight active
//             10-bit coefficient registers (COEFF1_0..3 and COEFF2_0..3).
//  Ports    : clk_i         - clock, rising edge
//             reset_i       - asynchronous active-high reset
//             cfg_start_i   - one-cycle pulse that starts a new load
//             cfg_bit_i     - serial data bit, MSB first
//             cfg_valid_i   - cfg_bit_i is valid this cycle
//             cfg_ready_o   - a bit is accepted this cycle (SHIFT state)
//             coeff_sel_i   - coefficient index 0..3
//             coeff1_o      - COEFF1_[sel], registered, one cycle of latency
//             coeff2_o      - COEFF2_[sel], registered, one cycle of latency
//             cfg_done_o    - one-cycle pulse when a load commits
//             cfg_err_o     - sticky reject flag, cleared by start or reset
//             busy_o        - high while in SHIFT or CHECK
//  Option   : MODE_BITS_PARITY_EN - when defined, the stream is 86 bits and
//             the last bit is even parity over the 85 data bits.
//  Revision : 1.0 - initial release
// ============================================================================
module dsp19x2_mode_bits_unpacker #(
    parameter int                     COEFF_WIDTH = 10,
    parameter bit                     STRICT_FLAG = 1'b1,
    parameter logic [COEFF_WIDTH-1:0] RESET_COEFF = '0
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cfg_start_i,
    input  logic                   cfg_bit_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [1:0]             coeff_sel_i,
    output logic [COEFF_WIDTH-1:0] coeff1_o,
    output logic [COEFF_WIDTH-1:0] coeff2_o,
    output logic                   cfg_done_o,
    output logic                   cfg_err_o,
    output logic                   busy_o
);

    // The word layout is only defined for 10-bit coefficients.
    generate
        if (COEFF_WIDTH != 10) begin : g_bad_width
            $error("dsp19x2_mode_bits_unpacker: COEFF_WIDTH must be 10");
        end
    endgenerate

    // 8 coefficients + 4 don't-care bits + 1 flag bit = 85 data bits.
    localparam int DATA_BITS = 8 * COEFF_WIDTH + 5;
`ifdef MODE_BITS_PARITY_EN
    // Parity arrives last, so it sits in shadow bit 0 and the data is above it.
    localparam int STREAM_BITS = DATA_BITS + 1;
    localparam int DATA_LSB    = 1;
`else
    localparam int STREAM_BITS = DATA_BITS;
    localparam int DATA_LSB    = 0;
`endif
    localparam logic [6:0] LAST_IDX = 7'(STREAM_BITS - 1);
    localparam int         DATA_MSB = DATA_LSB + DATA_BITS - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SHIFT  = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_LOADED = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    logic [2:0]             state_q,  state_d;
    logic [6:0]             cnt_q,    cnt_d;
    logic [STREAM_BITS-1:0] shadow_q, shadow_d;
    logic                   err_q,    err_d;
    logic                   done_q,   done_d;
    logic [COEFF_WIDTH-1:0] c1_q [4];
    logic [COEFF_WIDTH-1:0] c1_d [4];
    logic [COEFF_WIDTH-1:0] c2_q [4];
    logic [COEFF_WIDTH-1:0] c2_d [4];
    logic [COEFF_WIDTH-1:0] coeff1_q, coeff1_d;
    logic [COEFF_WIDTH-1:0] coeff2_q, coeff2_d;

    logic w_flag_ok;
    logic w_parity_ok;
    logic w_accept;

    assign w_flag_ok = shadow_q[DATA_LSB] | ~STRICT_FLAG;
`ifdef MODE_BITS_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_parity_ok = ~(^shadow_q);
`else
    assign w_parity_ok = 1'b1;
`endif
    assign w_accept = w_flag_ok & w_parity_ok;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        err_d    = err_q;
        done_d   = 1'b0;
        c1_d     = c1_q;
        c2_d     = c2_q;

        if (cfg_start_i) begin
            // Start wins over everything, including a same-cycle bit transfer.
            state_d  = S_SHIFT;
            cnt_d    = '0;
            shadow_d = '0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    // cfg_ready_o is high throughout SHIFT, so valid alone
                    // marks a transfer here.
                    if (cfg_valid_i) begin
                        shadow_d = {shadow_q[STREAM_BITS-2:0], cfg_bit_i};
                        cnt_d    = cnt_q + 7'd1;
                        if (cnt_q == LAST_IDX) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        for (int i = 0; i < 4; i++) begin
                            c1_d[i] = shadow_q[DATA_MSB - 2*COEFF_WIDTH*i -: COEFF_WIDTH];
                            c2_d[i] = shadow_q[DATA_MSB - COEFF_WIDTH - 2*COEFF_WIDTH*i -: COEFF_WIDTH];
                        end
                        done_d  = 1'b1;
                        state_d = S_LOADED;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end
                end
                default: ;
            endcase
        end

        // Select from the next-state coefficients so a fresh commit is
        // visible on the outputs in the same cycle as cfg_done_o.
        coeff1_d = c1_d[coeff_sel_i];
        coeff2_d = c2_d[coeff_sel_i];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            coeff1_q <= RESET_COEFF;
            coeff2_q <= RESET_COEFF;
            for (int i = 0; i < 4; i++) begin
                c1_q[i] <= RESET_COEFF;
                c2_q[i] <= RESET_COEFF;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            done_q   <= done_d;
            coeff1_q <= coeff1_d;
            coeff2_q <= coeff2_d;
            c1_q     <= c1_d;
            c2_q     <= c2_d;
        end
    end

    assign cfg_ready_o = (state_q == S_SHIFT);
    assign busy_o      = (state_q == S_SHIFT) || (state_q == S_CHECK);
    assign cfg_done_o  = done_q;
    assign cfg_err_o   = err_q;
    assign coeff1_o    = coeff1_q;
    assign coeff2_o    = coeff2_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp19x2_mode_bits_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp19x2_mode_bits_unpacker
//  Purpose  : Self-checking bench for dsp19x2_mode_bits_unpacker. A strict
//             instance and a non-strict instance share the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dsp19x2_mode_bits_unpacker;

`ifdef MODE_BITS_PARITY_EN
    localparam int LEN = 86;
`else
    localparam int LEN = 85;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cbit = 1'b0;
    logic       cvalid = 1'b0;
    logic [1:0] sel = 2'd0;

    logic       ready, done, err, busy;
    logic [9:0] c1, c2;
    logic       ns_ready, ns_done, ns_err, ns_busy;
    logic [9:0] ns_c1, ns_c2;

    always #5 clk = ~clk;

    dsp19x2_mode_bits_unpacker #(.COEFF_WIDTH(10), .STRICT_FLAG(1'b1), .RESET_COEFF(10'h000)) dut (
        .clk_i(clk), .reset_i(rst), .cfg_start_i(start), .cfg_bit_i(cbit),
        .cfg_valid_i(cvalid), .cfg_ready_o(ready), .coeff_sel_i(sel),
        .coeff1_o(c1), .coeff2_o(c2), .cfg_done_o(done), .cfg_err_o(err),
        .busy_o(busy)
    );

    dsp19x2_mode_bits_unpacker #(.COEFF_WIDTH(10), .STRICT_FLAG(1'b0), .RESET_COEFF(10'h000)) dut_ns (
        .clk_i(clk), .reset_i(rst), .cfg_start_i(start), .cfg_bit_i(cbit),
        .cfg_valid_i(cvalid), .cfg_ready_o(ns_ready), .coeff_sel_i(sel),
        .coeff1_o(ns_c1), .coeff2_o(ns_c2), .cfg_done_o(ns_done), .cfg_err_o(ns_err),
        .busy_o(ns_busy)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q[$];
    logic [9:0]  m_c1[4];
    logic [9:0]  m_c2[4];
    logic [9:0]  p_c1[4];
    logic [9:0]  p_c2[4];
    logic [84:0] word;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [31:0] got);
        logic [31:0] e;
        if (sb_q.size() == 0) e = 32'hFFFF_FFFF;
        else                  e = sb_q.pop_front();
        chk(tag, got, e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic build(input logic flag, input bit rnd);
        for (int i = 0; i < 4; i++) begin
            p_c1[i] = rnd ? 10'($urandom_range(0, 1023)) : 10'h101 + 10'(i);
            p_c2[i] = rnd ? 10'($urandom_range(0, 1023)) : 10'h201 + 10'(i);
        end
        word = {p_c1[0], p_c2[0], p_c1[1], p_c2[1], p_c1[2], p_c2[2],
                p_c1[3], p_c2[3], 4'b1010, flag};
    endtask

    task automatic commit_model;
        for (int i = 0; i < 4; i++) begin
            m_c1[i] = p_c1[i];
            m_c2[i] = p_c2[i];
        end
    endtask

    // Starts a load, streams up to stop_after bits, then waits for the result.
    task automatic load(input bit gap, input int stop_after, input bit start_with_bit,
                        output int done_cyc, output logic [1:0] outcome, output bit ns_seen);
        logic [LEN-1:0] s;
        int idx, cyc, guard;
        bit acc;
`ifdef MODE_BITS_PARITY_EN
        s = {word, ^word};
`else
        s = word;
`endif
        outcome  = 2'd0;
        done_cyc = -1;
        ns_seen  = 1'b0;
        start  = 1'b1;
        cvalid = start_with_bit;
        cbit   = 1'b1;
        step;
        start = 1'b0;
        cyc   = 1;
        chk("shift_ready", {31'd0, ready}, 32'd1);
        chk("shift_busy", {31'd0, busy}, 32'd1);
        chk("err_clr_on_start", {31'd0, err}, 32'd0);
        idx   = LEN - 1;
        guard = 0;
        while (idx >= 0 && guard < 2000 && (LEN - 1 - idx) < stop_after) begin
            cvalid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            cbit   = cvalid ? s[idx] : 1'($urandom_range(0, 1));
            acc    = cvalid && ready;
            step;
            cyc++;
            guard++;
            if (acc) idx--;
        end
        cvalid = 1'b0;
        if (idx >= 0) return;
        chk("check_ready", {31'd0, ready}, 32'd0);
        chk("check_busy", {31'd0, busy}, 32'd1);
        guard = 0;
        while (outcome == 2'd0 && guard < 8) begin
            step;
            cyc++;
            guard++;
            if (ns_done) ns_seen = 1'b1;
            if (done) begin
                outcome  = 2'd1;
                done_cyc = cyc;
            end else if (err) begin
                outcome  = 2'd2;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic sweep(input string tag);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            sb_q.push_back({22'd0, m_c1[s]});
            sb_q.push_back({22'd0, m_c2[s]});
            step;
            sb_pop({tag, "_c1"}, {22'd0, c1});
            sb_pop({tag, "_c2"}, {22'd0, c2});
        end
    endtask

    int         dcyc;
    logic [1:0] oc;
    bit         nsd;

    initial begin
        for (int i = 0; i < 4; i++) begin
            m_c1[i] = 10'h000;
            m_c2[i] = 10'h000;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c1", {22'd0, c1}, 32'h000);
        chk("rst_c2", {22'd0, c2}, 32'h000);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        step;
        chk("idle_ready", {31'd0, ready}, 32'd0);

        // A: fixed pattern, valid held high, commit in cycle LEN+2.
        build(1'b1, 1'b0);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'(LEN + 2));
        load(1'b0, LEN, 1'b0, dcyc, oc, nsd);
        sb_pop("A_outcome", {30'd0, oc});
        sb_pop("A_done_cycle", 32'(dcyc));
        commit_model();
        step;
        chk("A_done_pulse", {31'd0, done}, 32'd0);
        chk("A_loaded_busy", {31'd0, busy}, 32'd0);
        sweep("A");

        // B: flag = 0, strict rejects and keeps A; non-strict commits.
        build(1'b0, 1'b1);
        sb_q.push_back(32'd2);
        sb_q.push_back(32'd1);
        load(1'b0, LEN, 1'b0, dcyc, oc, nsd);
        sb_pop("B_outcome", {30'd0, oc});
        sb_pop("B_ns_done", {31'd0, nsd});
        repeat (3) step;
        chk("B_err_sticky", {31'd0, err}, 32'd1);
        chk("B_err_busy", {31'd0, busy}, 32'd0);
        sweep("B");
        chk("B_ns_c1", {22'd0, ns_c1}, {22'd0, p_c1[3]});
        chk("B_ns_c2", {22'd0, ns_c2}, {22'd0, p_c2[3]});

        // C: random valid gaps.
        build(1'b1, 1'b1);
        sb_q.push_back(32'd1);
        load(1'b1, LEN, 1'b0, dcyc, oc, nsd);
        sb_pop("C_outcome", {30'd0, oc});
        commit_model();
        sweep("C");

        // D: restart after 40 bits, only the second word commits.
        build(1'b1, 1'b1);
        load(1'b0, 40, 1'b0, dcyc, oc, nsd);
        build(1'b1, 1'b1);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'(LEN + 2));
        load(1'b0, LEN, 1'b0, dcyc, oc, nsd);
        sb_pop("D_outcome", {30'd0, oc});
        sb_pop("D_done_cycle", 32'(dcyc));
        commit_model();
        sweep("D");

        // E: a valid bit alongside START must be dropped.
        build(1'b1, 1'b1);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'(LEN + 2));
        load(1'b0, LEN, 1'b1, dcyc, oc, nsd);
        sb_pop("E_outcome", {30'd0, oc});
        sb_pop("E_done_cycle", 32'(dcyc));
        commit_model();
        sweep("E");

        // F: asynchronous reset at bit 60 of a load.
        build(1'b1, 1'b1);
        load(1'b0, 60, 1'b0, dcyc, oc, nsd);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            m_c1[i] = 10'h000;
            m_c2[i] = 10'h000;
        end
        chk("F_async_c1", {22'd0, c1}, 32'h000);
        chk("F_async_c2", {22'd0, c2}, 32'h000);
        chk("F_async_busy", {31'd0, busy}, 32'd0);
        chk("F_async_ready", {31'd0, ready}, 32'd0);
        step;
        step;
        rst = 1'b0;
        step;
        chk("F_idle_busy", {31'd0, busy}, 32'd0);
        sweep("F");

        // G: normal load after the reset.
        build(1'b1, 1'b1);
        sb_q.push_back(32'd1);
        sb_q.push_back(32'(LEN + 2));
        load(1'b0, LEN, 1'b0, dcyc, oc, nsd);
        sb_pop("G_outcome", {30'd0, oc});
        sb_pop("G_done_cycle", 32'(dcyc));
        commit_model();
        sweep("G");

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp19x2_mode_bits_unpacker.md
Name: dsp19x2_mode_bits_unpacker

Overview:
- Receiver end of the DSP19X2 MODE_BITS configuration word.
- The forward DSP19X2 mapping packs eight 10-bit coefficients plus a flag bit into an 85-bit MODE_BITS vector.
- This block accepts that vector as a serial, MSB-first bit stream with a valid/ready handshake, validates it, and unpacks it into active coefficient registers.
- Outputs are the selected COEFF1_x/COEFF2_x pair, for feeding the A-inputs of a behavioural or emulated DSP19X2 in coefficient mode.

Parameters:
- COEFF_WIDTH, 10, width of each coefficient; fixed at 10 in this release, and any other value is a compile-time error.
- STRICT_FLAG, 1, 1 = the terminal flag bit must be 1 or the load is rejected; 0 = the flag is ignored.
- RESET_COEFF, 10'h000, value loaded into all eight active coefficient registers on reset.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CFG_START  input  1  single-cycle pulse that begins a new 85-bit load.
- CFG_BIT  input  1  serial MODE_BITS data bit, MSB (bit 84) first.
- CFG_VALID  input  1  CFG_BIT is valid this cycle.
- CFG_READY  output  1  block accepts a bit this cycle.
- COEFF_SEL  input  2  selects coefficient index 0..3.
- COEFF1  output  10  selected multiplier-1 coefficient (COEFF1_[COEFF_SEL]).
- COEFF2  output  10  selected multiplier-2 coefficient (COEFF2_[COEFF_SEL]).
- CFG_DONE  output  1  one-cycle pulse when a load commits.
- CFG_ERR  output  1  sticky; set on rejected load, cleared by CFG_START or RESET.
- BUSY  output  1  high while in SHIFT or CHECK.

Behaviour:
- Word layout, bit 84 down to bit 0:
  - [84:75] COEFF1_0, [74:65] COEFF2_0
  - [64:55] COEFF1_1, [54:45] COEFF2_1
  - [44:35] COEFF1_2, [34:25] COEFF2_2
  - [24:15] COEFF1_3, [14:5] COEFF2_3
  - [4:1] don't-care, discarded
  - [0] flag, required value 1
- States:
  - IDLE (reset state).
  - SHIFT: CFG_READY=1.
  - CHECK: one cycle.
  - LOADED.
  - ERROR.
- CFG_START in any state:
  - Go to SHIFT, clear the 7-bit bit counter and the 85-bit shadow register, clear CFG_ERR.
  - A restart in SHIFT discards the partial word.
  - CFG_START has priority over a same-cycle bit transfer; that bit is dropped.
- In SHIFT, a transfer occurs when CFG_VALID && CFG_READY:
  - shadow <= {shadow[83:0], CFG_BIT}; counter increments.
  - On the 85th accepted bit (counter == 84 before the increment), go to CHECK; CFG_READY is 0 from the next cycle.
  - CFG_VALID low stalls the load indefinitely, with no timeout.
- CHECK:
  - If the flag is 1, or STRICT_FLAG == 0: copy the shadow into the active registers, pulse CFG_DONE for 1 cycle, go to LOADED.
  - Otherwise: active registers unchanged, set CFG_ERR, go to ERROR.
- In IDLE, LOADED and ERROR, CFG_READY = 0 and CFG_BIT/CFG_VALID are ignored.
- Active coefficient registers change only at commit or reset. A mid-load RESET leaves them at RESET_COEFF and returns the block to IDLE.
- COEFF1/COEFF2:
  - Registered; they reflect COEFF_SEL from the previous cycle (latency 1).
  - The cycle after commit, they show the new value for the current select.
- Reset values:
  - CFG_READY = 0, CFG_DONE = 0, CFG_ERR = 0, BUSY = 0.
  - COEFF1 = COEFF2 = RESET_COEFF.
  - Counter = 0, shadow = 0.
- Minimum load time: START cycle + 85 transfer cycles + 1 CHECK cycle. With VALID held high after START, CFG_DONE pulses in cycle 87 after START.

Optional Feature:
- Macro: MODE_BITS_PARITY_EN.
- Defined:
  - The stream is 86 bits; bit 85 is an even-parity bit over the 85 data bits, sent last.
  - CHECK also rejects the load on a parity mismatch (sets CFG_ERR, goes to ERROR).
  - Minimum load becomes 88 cycles.
- Undefined: 85-bit stream, no parity logic.

Test Plan:
- Reset, COEFF_SEL=0 -> COEFF1=COEFF2=10'h000, CFG_READY=0, BUSY=0, CFG_ERR=0.
- START then stream COEFF1_x=10'h101+x, COEFF2_x=10'h201+x, dc=4'b1010, flag=1 with VALID held high -> CFG_DONE in cycle 87. Sweeping COEFF_SEL 0..3 gives COEFF1=10'h101..10'h104 and COEFF2=10'h201..10'h204 at 1-cycle latency.
- Same stream with flag=0, STRICT_FLAG=1 -> CFG_ERR=1, state ERROR, coefficients keep their prior values. With STRICT_FLAG=0 -> commits, CFG_DONE pulses.
- Random CFG_VALID gaps (~50% duty) during a load -> exactly 85 bits accepted, correct unpack; no transfer is counted while VALID=0.
- START after 40 bits, then a full new word -> only the second word commits. START in the same cycle as a valid bit -> that bit is dropped and the counter is 0.
- RESET asserted at bit 60 of a load that follows a committed word -> coefficients return to RESET_COEFF asynchronously and the state is IDLE. A later full load commits normally.
